// File: rtl/vram_wr_arbiter_if.sv
// Write-port bundle between the three VRAM writers and the arbiter, plus the
// registered beat handed to the downstream VRAM router.
interface vram_wr_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8
);
    logic [2:0][ADDR_W-1:0] req_wraddr;
    logic [2:0]             req_wren;
    logic [2:0][DATA_W-1:0] req_wrdata;
    logic [2:0][BE_W-1:0]   req_byteena;
    logic [2:0]             req_lock;
    logic [2:0]             req_ready;

    logic                   vram_wren;
    logic [ADDR_W-1:0]      vram_wraddr;
    logic [1:0]             vram_region;
    logic [ADDR_W-1:0]      vram_offset;
    logic [DATA_W-1:0]      vram_wrdata;
    logic [BE_W-1:0]        vram_byteena;
    logic                   vram_ready;

    modport master (
        output req_wraddr, req_wren, req_wrdata, req_byteena, req_lock,
        input  req_ready,
        input  vram_wren, vram_wraddr, vram_region, vram_offset, vram_wrdata, vram_byteena,
        output vram_ready
    );

    modport slave (
        input  req_wraddr, req_wren, req_wrdata, req_byteena, req_lock,
        output req_ready,
        output vram_wren, vram_wraddr, vram_region, vram_offset, vram_wrdata, vram_byteena,
        input  vram_ready
    );
endinterface

// File: rtl/vram_wr_arbiter.sv
// Round-robin VRAM write arbiter with burst lock, one-entry output register
// with backpressure, and region/offset decode of the winning word address.
module vram_wr_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    vram_wr_arbiter_if.slave   bus
);
    localparam logic [ADDR_W-1:0] PAT_BASE = ADDR_W'(32'h0800);
    localparam logic [ADDR_W-1:0] PAL_BASE = ADDR_W'(32'h1800);
    localparam logic [ADDR_W-1:0] SPR_BASE = ADDR_W'(32'h1A00);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        lock_id_q, lock_id_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [1:0]        region_q, region_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic [BE_W-1:0]   byteena_q, byteena_d;

    logic              load;
    logic [2:0][1:0]   cand;
    logic [1:0]        gnt;
    logic              gnt_vld;
    logic              accept;
    logic [ADDR_W-1:0] gnt_addr;
    logic [1:0]        dec_region;
    logic [ADDR_W-1:0] dec_offset;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            ptr_q     <= 2'd0;
            lock_id_q <= 2'd0;
            wren_q    <= 1'b0;
            wraddr_q  <= '0;
            region_q  <= 2'd0;
            offset_q  <= '0;
            wrdata_q  <= '0;
            byteena_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
            wren_q    <= wren_d;
            wraddr_q  <= wraddr_d;
            region_q  <= region_d;
            offset_q  <= offset_d;
            wrdata_q  <= wrdata_d;
            byteena_q <= byteena_d;
        end
    end

    // Search runs highest-priority-last so the first valid candidate wins.
    always_comb begin
        load    = !wren_q || bus.vram_ready;
        cand[0] = ptr_q;
        cand[1] = inc3(ptr_q);
        cand[2] = inc3(cand[1]);
        gnt     = 2'd0;
        gnt_vld = 1'b0;
        if (state_q == LOCKED) begin
            gnt     = lock_id_q;
            gnt_vld = 1'b1;
        end else begin
            for (int k = 2; k >= 0; k--) begin
                if (bus.req_wren[cand[k]]) begin
                    gnt     = cand[k];
                    gnt_vld = 1'b1;
                end
            end
        end
        bus.req_ready = 3'b000;
        if (load && gnt_vld) bus.req_ready[gnt] = 1'b1;
        accept = load && gnt_vld && bus.req_wren[gnt];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB: begin
                if (accept) begin
                    ptr_d = inc3(gnt);
                    if (bus.req_lock[gnt]) begin
                        state_d   = LOCKED;
                        lock_id_d = gnt;
                    end
                end
            end
            LOCKED: begin
                // An idle, unlocked owner releases the lock even without a beat.
                if (accept ? !bus.req_lock[gnt]
                           : (!bus.req_wren[lock_id_q] && !bus.req_lock[lock_id_q]))
                    state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        gnt_addr = bus.req_wraddr[gnt];
        if (gnt_addr < PAT_BASE) begin
            dec_region = 2'd0;
            dec_offset = gnt_addr;
        end else if (gnt_addr < PAL_BASE) begin
            dec_region = 2'd1;
            dec_offset = gnt_addr - PAT_BASE;
        end else if (gnt_addr < SPR_BASE) begin
            dec_region = 2'd2;
            dec_offset = gnt_addr - PAL_BASE;
        end else begin
            dec_region = 2'd3;
            dec_offset = gnt_addr - SPR_BASE;
        end
    end

    always_comb begin
        wren_d    = wren_q;
        wraddr_d  = wraddr_q;
        region_d  = region_q;
        offset_d  = offset_q;
        wrdata_d  = wrdata_q;
        byteena_d = byteena_q;
        if (accept) begin
            wren_d    = 1'b1;
            wraddr_d  = gnt_addr;
            region_d  = dec_region;
            offset_d  = dec_offset;
            wrdata_d  = bus.req_wrdata[gnt];
            byteena_d = bus.req_byteena[gnt];
        end else if (bus.vram_ready) begin
            wren_d = 1'b0;
        end
    end

    assign bus.vram_wren    = wren_q;
    assign bus.vram_wraddr  = wraddr_q;
    assign bus.vram_region  = region_q;
    assign bus.vram_offset  = offset_q;
    assign bus.vram_wrdata  = wrdata_q;
    assign bus.vram_byteena = byteena_q;
endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Bench for vram_wr_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration and output-register rules.
module tb_vram_wr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vram_wr_arbiter_if #(.ADDR_W(13), .DATA_W(64), .BE_W(8)) bus ();

    vram_wr_arbiter #(.ADDR_W(13), .DATA_W(64), .BE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pointer, lock owner, and the beat sitting in the output register.
    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_lid = 0;
    bit          m_ov = 0;
    logic [12:0] m_oaddr = '0;
    logic [63:0] m_odata = '0;
    logic [7:0]  m_obe = '0;

    int          base_tbl[4] = '{0, 'h800, 'h1800, 'h1A00};
    logic [12:0] bnd_addr[7] = '{13'h07FF, 13'h0800, 13'h17FF, 13'h1800, 13'h19FF, 13'h1A00, 13'h1FFF};
    logic [1:0]  bnd_reg[7]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [12:0] bnd_off[7]  = '{13'h7FF, 13'h0, 13'hFFF, 13'h0, 13'h1FF, 13'h0, 13'h5FF};

    function automatic int region_of(input int a);
        int r = 0;
        for (int k = 0; k < 4; k++) if (a >= base_tbl[k]) r = k;
        return r;
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r = 3'b000;
        if (m_ov && !bus.vram_ready) return r;
        if (m_locked) begin
            r[m_lid] = 1'b1;
            return r;
        end
        for (int k = 0; k < 3; k++) begin
            if (bus.req_wren[(m_ptr + k) % 3]) begin
                r[(m_ptr + k) % 3] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [2:0] r;
        int g;
        r = exp_ready();
        g = -1;
        for (int k = 0; k < 3; k++) if (r[k]) g = k;
        if (reset) begin
            m_ptr <= 0; m_locked <= 0; m_lid <= 0;
            m_ov <= 0; m_oaddr <= '0; m_odata <= '0; m_obe <= '0;
        end else if (g >= 0 && bus.req_wren[g]) begin
            m_ov <= 1; m_oaddr <= bus.req_wraddr[g];
            m_odata <= bus.req_wrdata[g]; m_obe <= bus.req_byteena[g];
            if (!m_locked) begin
                m_ptr <= (g + 1) % 3;
                if (bus.req_lock[g]) begin m_locked <= 1; m_lid <= g; end
            end else if (!bus.req_lock[g]) begin
                m_locked <= 0;
            end
        end else begin
            if (bus.vram_ready) m_ov <= 0;
            if (m_locked && !bus.req_wren[m_lid] && !bus.req_lock[m_lid]) m_locked <= 0;
        end
    end

    task automatic idle_inputs();
        bus.req_wren = '0; bus.req_lock = '0;
        for (int i = 0; i < 3; i++) begin
            bus.req_wraddr[i] = '0; bus.req_wrdata[i] = '0; bus.req_byteena[i] = '0;
        end
    endtask

    task automatic rand_req(input int i);
        bus.req_wraddr[i]  = 13'($urandom_range(0, 8191));
        bus.req_wrdata[i]  = {$urandom, $urandom};
        bus.req_byteena[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        idle_inputs(); bus.vram_ready = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.vram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", bus.vram_wren); end
        checks++; if ({bus.vram_wraddr, bus.vram_offset, bus.vram_region} !== '0) begin errors++; $display("FAIL reset_addr got=%h/%h/%0d exp=0", bus.vram_wraddr, bus.vram_offset, bus.vram_region); end
        checks++; if ({bus.vram_wrdata, bus.vram_byteena} !== '0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0", bus.vram_wrdata, bus.vram_byteena); end
        checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req_wren = 3'b001; bus.req_wraddr[0] = 13'h0801;
        bus.req_wrdata[0] = 64'hDEADBEEF_00000001; bus.req_byteena[0] = 8'hFF;
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", bus.req_ready); end
        @(negedge clk); bus.req_wren = '0; #1;
        checks++; if (bus.vram_wren !== 1'b1) begin errors++; $display("FAIL single_wren got=%b exp=1", bus.vram_wren); end
        checks++; if (bus.vram_region !== 2'd1 || bus.vram_offset !== 13'h0001) begin errors++; $display("FAIL single_decode got=%0d/%h exp=1/0001", bus.vram_region, bus.vram_offset); end
        checks++; if (bus.vram_wrdata !== 64'hDEADBEEF_00000001 || bus.vram_byteena !== 8'hFF) begin errors++; $display("FAIL single_data got=%h/%h exp=deadbeef00000001/ff", bus.vram_wrdata, bus.vram_byteena); end
    endtask

    task automatic test_round_robin();
        int prev = -1;
        int cur;
        logic [12:0] gaddr = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus.req_wren = 3'b111;
            for (int i = 0; i < 3; i++) rand_req(i);
            #1;
            if (c > 0) begin
                checks++; if (bus.vram_wren !== 1'b1 || bus.vram_wraddr !== gaddr) begin errors++; $display("FAIL rr_out c=%0d got=%b/%h exp=1/%h", c, bus.vram_wren, bus.vram_wraddr, gaddr); end
            end
            cur = -1;
            for (int k = 0; k < 3; k++) if (bus.req_ready == (3'b001 << k)) cur = k;
            checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready()); end
            if (prev >= 0) begin
                checks++; if (cur !== (prev + 1) % 3) begin errors++; $display("FAIL rr_order c=%0d got=%0d exp=%0d", c, cur, (prev + 1) % 3); end
            end
            prev = cur;
            if (cur >= 0) gaddr = bus.req_wraddr[cur];
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_lock_burst();
        logic [12:0] gaddr[6];
        logic [2:0]  exp_r;
        @(negedge clk); idle_inputs(); bus.req_wren = 3'b001; rand_req(0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.req_wren = 3'b111;
            for (int i = 0; i < 3; i++) rand_req(i);
            bus.req_lock = (c < 3) ? 3'b010 : 3'b000;
            #1;
            exp_r = (c < 4) ? 3'b010 : (c == 4) ? 3'b100 : 3'b001;
            gaddr[c] = (c < 4) ? bus.req_wraddr[1] : (c == 4) ? bus.req_wraddr[2] : bus.req_wraddr[0];
            checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL lock_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r); end
            if (c > 0) begin
                checks++; if (bus.vram_wraddr !== gaddr[c-1]) begin errors++; $display("FAIL lock_out c=%0d got=%h exp=%h", c, bus.vram_wraddr, gaddr[c-1]); end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [12:0] a0, a2;
        logic [63:0] d0, d2;
        @(negedge clk); idle_inputs(); bus.vram_ready = 1'b1;
        bus.req_wren = 3'b001; rand_req(0); a0 = bus.req_wraddr[0]; d0 = bus.req_wrdata[0];
        @(negedge clk); bus.req_wren = 3'b100; rand_req(2); a2 = bus.req_wraddr[2]; d2 = bus.req_wrdata[2];
        bus.vram_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=000", c, bus.req_ready); end
            checks++; if (bus.vram_wren !== 1'b1 || bus.vram_wraddr !== a0 || bus.vram_wrdata !== d0) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.vram_wren, bus.vram_wraddr, bus.vram_wrdata, a0, d0); end
            @(negedge clk);
        end
        bus.vram_ready = 1'b1; #1;
        checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL bp_release got=%b exp=100", bus.req_ready); end
        @(negedge clk); bus.req_wren = '0; #1;
        checks++; if (bus.vram_wren !== 1'b1 || bus.vram_wraddr !== a2 || bus.vram_wrdata !== d2) begin errors++; $display("FAIL bp_next got=%b/%h/%h exp=1/%h/%h", bus.vram_wren, bus.vram_wraddr, bus.vram_wrdata, a2, d2); end
    endtask

    task automatic test_regions();
        @(negedge clk); idle_inputs(); bus.vram_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 7) begin bus.req_wren = 3'b001; bus.req_wraddr[0] = bnd_addr[c]; end
            else bus.req_wren = 3'b000;
            #1;
            if (c > 0) begin
                checks++; if (bus.vram_region !== bnd_reg[c-1] || bus.vram_offset !== bnd_off[c-1]) begin errors++; $display("FAIL region addr=%h got=%0d/%h exp=%0d/%h", bnd_addr[c-1], bus.vram_region, bus.vram_offset, bnd_reg[c-1], bnd_off[c-1]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int ereg;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                rand_req(i);
                bus.req_wren[i] = ($urandom_range(0, 9) < 7);
                bus.req_lock[i] = ($urandom_range(0, 9) < 3);
            end
            bus.vram_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready()); end
            checks++; if (bus.vram_wren !== m_ov) begin errors++; $display("FAIL rnd_wren c=%0d got=%b exp=%b", c, bus.vram_wren, m_ov); end
            if (m_ov) begin
                ereg = region_of(int'(m_oaddr));
                checks++;
                if (bus.vram_wraddr !== m_oaddr || bus.vram_wrdata !== m_odata || bus.vram_byteena !== m_obe ||
                    bus.vram_region !== 2'(ereg) || bus.vram_offset !== 13'(int'(m_oaddr) - base_tbl[ereg])) begin
                    errors++;
                    $display("FAIL rnd_beat c=%0d got=%h/%h/%h/%0d/%h exp=%h/%h/%h/%0d/%h", c, bus.vram_wraddr, bus.vram_wrdata, bus.vram_byteena, bus.vram_region, bus.vram_offset, m_oaddr, m_odata, m_obe, ereg, 13'(int'(m_oaddr) - base_tbl[ereg]));
                end
            end
        end
        @(negedge clk); idle_inputs(); bus.vram_ready = 1'b1;
    endtask

    task automatic test_reset_locked();
        @(negedge clk); idle_inputs(); bus.vram_ready = 1'b1; reset = 1'b1;
        @(negedge clk); reset = 1'b0; bus.req_wren = 3'b100; bus.req_lock = 3'b100; rand_req(2);
        @(negedge clk); bus.vram_ready = 1'b0; #1;
        checks++; if (bus.vram_wren !== 1'b1) begin errors++; $display("FAIL rl_pending got=%b exp=1", bus.vram_wren); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; bus.req_wren = 3'b111; bus.req_lock = 3'b000; bus.vram_ready = 1'b1;
        for (int i = 0; i < 3; i++) rand_req(i);
        #1;
        checks++; if (bus.vram_wren !== 1'b0) begin errors++; $display("FAIL rl_wren got=%b exp=0", bus.vram_wren); end
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rl_first got=%b exp=001", bus.req_ready); end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        idle_inputs(); bus.vram_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_backpressure();
        test_regions();
        test_random();
        test_reset_locked();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vram_wr_arbiter.md
Name: vram_wr_arbiter

Overview:
- Shares the single VRAM write port between three writers: the h2f bus writer (requester 0) and the two vram_sync writers (requesters 1, 2).
- Arbitrates with round-robin plus burst lock. Registers the winning write into a one-entry output stage with backpressure.
- Decodes the 64-bit word address into region (tile/pattern/palette/sprite) and region-local offset for the downstream VRAM router.

Parameters:
- ADDR_W, 13, word address width (64-bit words, 64 KiB space)
- DATA_W, 64, write data width
- BE_W, 8, byte-enable width (DATA_W/8)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_wraddr[0:2]  in  3xADDR_W  per-requester word address
- req_wren[0:2]  in  3x1  per-requester write valid
- req_wrdata[0:2]  in  3xDATA_W  per-requester data
- req_byteena[0:2]  in  3xBE_W  per-requester byte enables
- req_lock[0:2]  in  3x1  hold grant after this beat
- req_ready[0:2]  out  3x1  beat accepted when wren&ready
- vram_wren  out  1  output write valid
- vram_wraddr  out  ADDR_W  full word address
- vram_region  out  2  0 tile, 1 pattern, 2 palette, 3 sprite
- vram_offset  out  ADDR_W  address minus region base
- vram_wrdata  out  DATA_W  data
- vram_byteena  out  BE_W  byte enables
- vram_ready  in  1  downstream accepts beat when wren&ready

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset sets all of the following; reset mid-burst discards the lock and any held beat:
  - vram_wren=0, vram_wraddr/offset/wrdata/byteena=0, vram_region=0
  - rr pointer=0, state=ARB, locked id=0
- Output stage: one register. "load" = (!vram_wren | vram_ready). req_ready is all-zero when !load.
- ARB state:
  - If load, grant the first requester with wren=1, searching from rr pointer upward modulo 3.
  - req_ready[g]=1 combinationally for the granted requester only.
  - Pointer advances to g+1 mod 3 on every accepted beat.
- LOCKED state:
  - Only the locked id may be granted; others get ready=0 even if it is idle.
  - Pointer does not move while locked.
- Transitions:
  - ARB->LOCKED on an accepted beat with req_lock[g]=1.
  - LOCKED->ARB on an accepted beat with lock=0.
  - LOCKED->ARB also when the locked requester has lock=0 and wren=0 in any cycle.
- Latency: accepted beat appears on vram_* the next cycle. vram_wren stays high, data stable, until vram_ready. Throughput is 1 beat/cycle when vram_ready is held high.
- Same-cycle case: vram_ready=1 with a new grant drains the old beat and loads the new one; no bubble.
- Region decode (word addresses):
  - 0x0000-0x07FF tile
  - 0x0800-0x17FF pattern
  - 0x1800-0x19FF palette
  - 0x1A00-0x1FFF sprite
  - offset = addr - base, zero-extended to ADDR_W
  - Registered with the beat.
- byteena=0 beats are still arbitrated and passed through unchanged.
- No requester is starved outside LOCKED: with all requesters continuously valid, each waits at most 2 beats.

Test Plan:
- Reset, then r0 writes addr 0x0801, data 0xDEADBEEF_00000001, be 0xFF, vram_ready=1.
  -> Next cycle: vram_wren=1, region=1, offset=0x0001, same data/be.
  -> req_ready[0]=1 in the request cycle.
- r0, r1, r2 all valid continuously, vram_ready=1.
  -> Grant order 0,1,2,0,1,2. One beat per cycle. Pointer wraps correctly.
- r1 sends 4 beats with lock=1,1,1,0 while r0, r2 are valid.
  -> Four consecutive r1 beats on output, then r2 granted next (pointer was 2).
  -> r0, r2 ready=0 throughout the burst.
- Beat held with vram_ready=0 for 3 cycles.
  -> Output unchanged, all req_ready=0.
  -> Then vram_ready=1 with r2 valid: r2's beat appears the following cycle, no gap.
- Boundary addresses 0x07FF, 0x0800, 0x17FF, 0x1800, 0x19FF, 0x1A00, 0x1FFF.
  -> Regions 0,1,1,2,2,3,3.
  -> Offsets 0x7FF, 0, 0xFFF, 0, 0x1FF, 0, 0x5FF.
- Assert reset while r2 is LOCKED with a beat pending.
  -> Next cycle: vram_wren=0, state ARB, pointer 0.
  -> Post-reset with all valid: r0 granted first.
